hsid_mc_fifo: RTL and testbench
===============================

Name: hsid_mc_fifo

Overview:
Multi-channel circular FIFO for band/pixel streams. NUM_CH independent queues share one write port and one read port, each selected by a channel index. Per-channel loop (recirculate) mode with lap detection, registered read data with a valid strobe, and per-channel status flags. Generalises the single-queue HSID FIFO to multiple channels with a read handshake and a programmable almost-full threshold that can span the full depth.

Parameters:
DATA_WIDTH, 16, word width in bits
FIFO_ADDR_WIDTH, 3, log2 of per-channel depth; DEPTH = 2**FIFO_ADDR_WIDTH
NUM_CH, 4, number of channels, >=1; CH_W = max(1,$clog2(NUM_CH)) is a localparam

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of all channels, highest priority
wr_en  in  1  write request
wr_ch  in  CH_W  write channel index
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request
rd_ch  in  CH_W  read channel index
loop_en  in  NUM_CH  per-channel loop mode
almost_full_threshold  in  FIFO_ADDR_WIDTH+1  shared almost-full level, 0..DEPTH
rd_data  out  DATA_WIDTH  registered read word
rd_valid  out  1  rd_data valid this cycle
rd_ch_q  out  CH_W  channel that produced rd_data
full  out  NUM_CH  count==DEPTH per channel
empty  out  NUM_CH  count==0 per channel
almost_full  out  NUM_CH  count>=almost_full_threshold per channel
loop_lap  out  NUM_CH  one-cycle pulse: looping channel completed one full recirculation

Behaviour:
- Reset (rst_n low, async): all pointers, counts and lap counters 0; rd_data=0, rd_valid=0, rd_ch_q=0, loop_lap=0; memory contents zeroed. Flags follow counts: empty=all 1s, full=0.
- clear=1: same state as reset, applied on the clock edge; overrides all other requests that cycle; pending rd_valid for the next cycle is suppressed.
- Per-channel count width FIFO_ADDR_WIDTH+1; pointers FIFO_ADDR_WIDTH bits, natural wrap at DEPTH.
- Status outputs are combinational from registered counts.
- Channel index >= NUM_CH: request ignored, no state change.
- Read accepted iff rd_en && !empty[rd_ch]. On the edge: rd_data<=mem[rd_ch][rd_ptr], rd_ptr++, rd_ch_q<=rd_ch, rd_valid<=1. Otherwise rd_valid<=0 and rd_data holds its last value. Latency is 1 cycle from request to rd_valid.
- Write accepted iff wr_en && !loop_en[wr_ch] && (!full[wr_ch] || read accepted on same channel this cycle). On the edge: mem[wr_ch][wr_ptr]<=wr_data, wr_ptr++.
- Count update per channel: +1 for write only, -1 for read only, unchanged for both. Same-channel read+write when full is allowed and count stays DEPTH. Same-channel read+write when empty: the read is rejected, the write is accepted, count becomes 1, and there is no bypass.
- Different-channel read and write in the same cycle proceed independently.
- Loop mode (loop_en[c]=1): an accepted read on c also writes the popped word to mem[c][wr_ptr], and wr_ptr++. Count is unchanged. External writes to c are dropped.
- Lap counter per channel (FIFO_ADDR_WIDTH+1 bits): increments on each accepted looped read. When the increment reaches count[c], loop_lap[c] pulses in the next cycle and the counter returns to 0.
- Lap counter is zeroed whenever loop_en[c]=0.
- Loop on an empty channel: no operation and no lap pulse.
- almost_full_threshold=0 forces almost_full to all 1s. A threshold of DEPTH equals full.

Optional Feature:
HSID_FIFO_ERR_EN: when defined, adds two outputs, overflow_err[NUM_CH] and underflow_err[NUM_CH], each a sticky flag.
- overflow_err[c] is set by a rejected write to c caused by full or by loop mode.
- underflow_err[c] is set by rd_en on c while c is empty.
- Both flags are cleared by reset or clear.
When not defined, these ports and their logic are absent, and rejected requests are silently ignored.

Test Plan:
- Reset, then write 0x0011,0x0022,0x0033 to ch1 and read ch1 three times -> rd_valid one cycle after each read, rd_data 0x0011,0x0022,0x0033, rd_ch_q=1, empty[1]=1 at end, other channels untouched.
- Fill ch0 with 8 words (FIFO_ADDR_WIDTH=3), then write 0xBEEF -> full[0]=1, write dropped; same-cycle read+write ch0 -> count stays 8, 0xBEEF appears as 8th subsequent read.
- Threshold sweep on ch2 with threshold=5 -> almost_full[2] rises on 5th write; threshold=0 -> almost_full=4'b1111 after reset.
- ch3 holds 0xA,0xB,0xC with loop_en[3]=1, 6 consecutive reads -> rd_data A,B,C,A,B,C, count stays 3, loop_lap[3] pulses twice, external write to ch3 dropped.
- Write ch0 while reading ch2 in the same cycle -> both accepted; empty read on ch1 -> rd_valid=0, with HSID_FIFO_ERR_EN underflow_err[1]=1.
- Mid-stream: assert rst_n low asynchronously between edges, and separately pulse clear with a read pending -> all outputs return to reset values immediately (reset) or at the edge (clear), no rd_valid after clear.

Source files
------------

// File: rtl/hsid_mc_fifo.sv
// hsid_mc_fifo: multi-channel circular FIFO for band/pixel streams.
//
// NUM_CH independent queues of DEPTH = 2**FIFO_ADDR_WIDTH words share one write
// port and one read port, each steered by a channel index. A channel in loop mode
// recirculates every word it pops back onto its own tail and pulses loop_lap once
// per complete pass over its contents.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   clear                  synchronous clear of all channels (beats every request)
//   wr_en/wr_ch/wr_data    write request, channel and word
//   rd_en/rd_ch            read request and channel
//   loop_en                per-channel recirculate mode
//   almost_full_threshold  shared almost-full level, 0..DEPTH
//   rd_data/rd_valid       registered read word and its strobe (1-cycle latency)
//   rd_ch_q                channel that produced rd_data
//   full/empty/almost_full per-channel status, combinational from counts
//   loop_lap               one-cycle pulse per completed recirculation
//
// Optional build macro HSID_FIFO_ERR_EN adds sticky per-channel overflow_err and
// underflow_err outputs.
module hsid_mc_fifo #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned FIFO_ADDR_WIDTH = 3,
   parameter int unsigned NUM_CH          = 4,
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [CH_W-1:0]            wr_ch,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       rd_en,
   input  logic [CH_W-1:0]            rd_ch,
   input  logic [NUM_CH-1:0]          loop_en,
   input  logic [FIFO_ADDR_WIDTH:0]   almost_full_threshold,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       rd_valid,
   output logic [CH_W-1:0]            rd_ch_q,
   output logic [NUM_CH-1:0]          full,
   output logic [NUM_CH-1:0]          empty,
   output logic [NUM_CH-1:0]          almost_full,
`ifdef HSID_FIFO_ERR_EN
   output logic [NUM_CH-1:0]          overflow_err,
   output logic [NUM_CH-1:0]          underflow_err,
`endif
   output logic [NUM_CH-1:0]          loop_lap
);

   localparam int unsigned DEPTH = 2**FIFO_ADDR_WIDTH;
   localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef logic [DATA_WIDTH-1:0]      word_t;
   typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;
   typedef logic [CNT_W-1:0]           cnt_t;

   word_t mem_q    [NUM_CH][DEPTH];
   word_t mem_d    [NUM_CH][DEPTH];
   ptr_t  wr_ptr_q [NUM_CH];
   ptr_t  wr_ptr_d [NUM_CH];
   ptr_t  rd_ptr_q [NUM_CH];
   ptr_t  rd_ptr_d [NUM_CH];
   cnt_t  count_q  [NUM_CH];
   cnt_t  count_d  [NUM_CH];
   cnt_t  lap_q    [NUM_CH];
   cnt_t  lap_d    [NUM_CH];

   logic [NUM_CH-1:0] loop_lap_q, loop_lap_d;
   word_t             rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic [CH_W-1:0]   rd_src_q, rd_src_d;

   logic  rd_ch_ok, wr_ch_ok;
   logic  rd_accept, rd_loop, wr_accept;
   word_t popped;
   cnt_t  lap_inc;
   logic  wr_hit, rd_pop;

   // Status from registered counts only.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         empty[c]       = (count_q[c] == '0);
         full[c]        = (count_q[c] == DEPTH_CNT);
         almost_full[c] = (count_q[c] >= almost_full_threshold);
      end
   end

   assign rd_ch_ok  = (32'(rd_ch) < NUM_CH);
   assign wr_ch_ok  = (32'(wr_ch) < NUM_CH);
   assign rd_accept = rd_en && rd_ch_ok && !empty[rd_ch];
   assign rd_loop   = rd_accept && loop_en[rd_ch];
   assign popped    = mem_q[rd_ch][rd_ptr_q[rd_ch]];
   // A full channel still takes a write when the same cycle pops from it.
   assign wr_accept = wr_en && wr_ch_ok && !loop_en[wr_ch] &&
                      (!full[wr_ch] || (rd_accept && (rd_ch == wr_ch)));

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      lap_d      = lap_q;
      loop_lap_d = '0;
      rd_valid_d = rd_accept;
      rd_data_d  = rd_data_q;
      rd_src_d   = rd_src_q;
      lap_inc    = '0;
      wr_hit     = 1'b0;
      rd_pop     = 1'b0;

      if (rd_accept) begin
         rd_data_d       = popped;
         rd_src_d        = rd_ch;
         rd_ptr_d[rd_ch] = rd_ptr_q[rd_ch] + 1'b1;
      end

      if (wr_accept) begin
         mem_d[wr_ch][wr_ptr_q[wr_ch]] = wr_data;
         wr_ptr_d[wr_ch]               = wr_ptr_q[wr_ch] + 1'b1;
      end

      // Loop channels never accept external writes, so this cannot collide with
      // the write above.
      if (rd_loop) begin
         mem_d[rd_ch][wr_ptr_q[rd_ch]] = popped;
         wr_ptr_d[rd_ch]               = wr_ptr_q[rd_ch] + 1'b1;
      end

      for (int c = 0; c < NUM_CH; c++) begin
         wr_hit = wr_accept && (wr_ch == CH_W'(c));
         rd_pop = rd_accept && (rd_ch == CH_W'(c)) && !loop_en[c];
         if (wr_hit && !rd_pop) begin
            count_d[c] = count_q[c] + 1'b1;
         end else if (!wr_hit && rd_pop) begin
            count_d[c] = count_q[c] - 1'b1;
         end

         if (!loop_en[c]) begin
            lap_d[c] = '0;
         end else if (rd_loop && (rd_ch == CH_W'(c))) begin
            lap_inc = lap_q[c] + 1'b1;
            if (lap_inc == count_q[c]) begin
               lap_d[c]      = '0;
               loop_lap_d[c] = 1'b1;
            end else begin
               lap_d[c] = lap_inc;
            end
         end
      end

      if (clear) begin
         mem_d      = '{default: '0};
         wr_ptr_d   = '{default: '0};
         rd_ptr_d   = '{default: '0};
         count_d    = '{default: '0};
         lap_d      = '{default: '0};
         loop_lap_d = '0;
         rd_valid_d = 1'b0;
         rd_data_d  = '0;
         rd_src_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '{default: '0};
         rd_ptr_q   <= '{default: '0};
         count_q    <= '{default: '0};
         lap_q      <= '{default: '0};
         loop_lap_q <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_src_q   <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         lap_q      <= lap_d;
         loop_lap_q <= loop_lap_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_src_q   <= rd_src_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_ch_q  = rd_src_q;
   assign loop_lap = loop_lap_q;

`ifdef HSID_FIFO_ERR_EN
   logic [NUM_CH-1:0] ovf_q, ovf_d, unf_q, unf_d;

   // In-range writes are only ever refused for full or loop mode.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (wr_en && wr_ch_ok && !wr_accept) begin
         ovf_d[wr_ch] = 1'b1;
      end
      if (rd_en && rd_ch_ok && empty[rd_ch]) begin
         unf_d[rd_ch] = 1'b1;
      end
      if (clear) begin
         ovf_d = '0;
         unf_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;
`endif

endmodule

// File: tb/tb_hsid_mc_fifo.sv
module tb_hsid_mc_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [15:0] wr_data;
   logic        rd_en;
   logic [1:0]  rd_ch;
   logic [3:0]  loop_en;
   logic [3:0]  almost_full_threshold;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [1:0]  rd_ch_q;
   logic [3:0]  full;
   logic [3:0]  empty;
   logic [3:0]  almost_full;
   logic [3:0]  loop_lap;
`ifdef HSID_FIFO_ERR_EN
   logic [3:0]  overflow_err;
   logic [3:0]  underflow_err;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [17:0] exp_q [$];

   always #5 clk = ~clk;

   hsid_mc_fifo #(
      .DATA_WIDTH      (16),
      .FIFO_ADDR_WIDTH (3),
      .NUM_CH          (4)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .clear                 (clear),
      .wr_en                 (wr_en),
      .wr_ch                 (wr_ch),
      .wr_data               (wr_data),
      .rd_en                 (rd_en),
      .rd_ch                 (rd_ch),
      .loop_en               (loop_en),
      .almost_full_threshold (almost_full_threshold),
      .rd_data               (rd_data),
      .rd_valid              (rd_valid),
      .rd_ch_q               (rd_ch_q),
      .full                  (full),
      .empty                 (empty),
      .almost_full           (almost_full),
`ifdef HSID_FIFO_ERR_EN
      .overflow_err          (overflow_err),
      .underflow_err         (underflow_err),
`endif
      .loop_lap              (loop_lap)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_ch   = 2'(ch);
      wr_data = d;
      cyc();
      wr_en   = 1'b0;
   endtask

   task automatic rd(input int ch, input logic [15:0] d);
      rd_en = 1'b1;
      rd_ch = 2'(ch);
      exp_q.push_back({2'(ch), d});
      cyc();
      rd_en = 1'b0;
   endtask

   // Monitor: every rd_valid must match the oldest expected read.
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", 32'(rd_data), 32'(e[15:0]));
               chk("rd_ch_q", 32'(rd_ch_q), 32'(e[17:16]));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
      rd_en = 1'b0; rd_ch = '0; loop_en = '0; almost_full_threshold = 4'd0;
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();

      // Reset state; threshold 0 forces almost_full everywhere.
      chk("rst_empty", 32'(empty), 32'hF);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_afull_thr0", 32'(almost_full), 32'hF);
      chk("rst_rd_valid", 32'(rd_valid), 32'h0);
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      chk("rst_rd_ch_q", 32'(rd_ch_q), 32'h0);
      chk("rst_loop_lap", 32'(loop_lap), 32'h0);
`ifdef HSID_FIFO_ERR_EN
      chk("rst_ovf", 32'(overflow_err), 32'h0);
      chk("rst_unf", 32'(underflow_err), 32'h0);
`endif
      almost_full_threshold = 4'd5;
      #1;
      chk("afull_thr5_idle", 32'(almost_full), 32'h0);

      // Basic write/read on ch1.
      wr(1, 16'h0011); wr(1, 16'h0022); wr(1, 16'h0033);
      chk("ch1_loaded_empty", 32'(empty), 32'hD);
      rd(1, 16'h0011); rd(1, 16'h0022); rd(1, 16'h0033);
      chk("ch1_drained_empty", 32'(empty), 32'hF);

      // Fill ch0, drop a write, then same-cycle read+write at full.
      for (int i = 0; i < 8; i++) wr(0, 16'h0100 + 16'(i));
      chk("ch0_full", 32'(full), 32'h1);
      wr(0, 16'hBEEF);
      chk("ch0_full_after_drop", 32'(full), 32'h1);
      wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'hBEEF;
      rd_en = 1'b1; rd_ch = 2'd0; exp_q.push_back({2'd0, 16'h0100});
      cyc();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("ch0_full_after_rw", 32'(full), 32'h1);
      for (int i = 1; i < 8; i++) rd(0, 16'h0100 + 16'(i));
      rd(0, 16'hBEEF);
      chk("ch0_drained_empty", 32'(empty), 32'hF);

      // Threshold sweep on ch2 (threshold 5).
      for (int i = 1; i <= 5; i++) begin
         wr(2, 16'h0200 + 16'(i));
         chk($sformatf("afull_ch2_w%0d", i), 32'(almost_full), (i >= 5) ? 32'h4 : 32'h0);
      end
      // Different-channel write and read in one cycle.
      wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'h0AAA;
      rd_en = 1'b1; rd_ch = 2'd2; exp_q.push_back({2'd2, 16'h0201});
      cyc();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("xch_ch0_written", 32'(empty), 32'hA);
      chk("xch_ch2_popped_afull", 32'(almost_full), 32'h0);
      almost_full_threshold = 4'd0;
      #1;
      chk("afull_thr0_midrun", 32'(almost_full), 32'hF);
      almost_full_threshold = 4'd5;
      for (int i = 2; i <= 5; i++) rd(2, 16'h0200 + 16'(i));
      rd(0, 16'h0AAA);
      chk("xch_drained", 32'(empty), 32'hF);

      // Loop mode on ch3.
      wr(3, 16'h000A); wr(3, 16'h000B); wr(3, 16'h000C);
      loop_en = 4'b1000;
      for (int i = 1; i <= 6; i++) begin
         if (i == 2) begin
            wr_en = 1'b1; wr_ch = 2'd3; wr_data = 16'hDEAD;
         end
         case ((i - 1) % 3)
            0:       rd(3, 16'h000A);
            1:       rd(3, 16'h000B);
            default: rd(3, 16'h000C);
         endcase
         wr_en = 1'b0;
         chk($sformatf("loop_lap_r%0d", i), 32'(loop_lap), (i == 3 || i == 6) ? 32'h8 : 32'h0);
      end
      loop_en = 4'b0000;
      cyc();
      chk("loop_lap_off", 32'(loop_lap), 32'h0);
      almost_full_threshold = 4'd3;
      #1;
      chk("loop_count_ge3", 32'(almost_full), 32'h8);
      almost_full_threshold = 4'd4;
      #1;
      chk("loop_count_lt4", 32'(almost_full), 32'h0);
      almost_full_threshold = 4'd5;
      rd(3, 16'h000A); rd(3, 16'h000B); rd(3, 16'h000C);
      chk("loop_drained", 32'(empty), 32'hF);

      // Read of an empty channel.
      rd_en = 1'b1; rd_ch = 2'd1;
      cyc();
      rd_en = 1'b0;
      chk("empty_rd_valid", 32'(rd_valid), 32'h0);
      chk("empty_rd_data_hold", 32'(rd_data), 32'h000C);
`ifdef HSID_FIFO_ERR_EN
      chk("unf_ch1", 32'(underflow_err), 32'h2);
      chk("ovf_ch0_ch3", 32'(overflow_err), 32'h9);
`endif

      // Asynchronous reset between edges.
      wr(2, 16'h0055);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_empty", 32'(empty), 32'hF);
      chk("async_rst_rd_data", 32'(rd_data), 32'h0);
      chk("async_rst_rd_valid", 32'(rd_valid), 32'h0);
`ifdef HSID_FIFO_ERR_EN
      chk("async_rst_unf", 32'(underflow_err), 32'h0);
`endif
      cyc();
      rst_n = 1'b1;
      cyc();

      // Clear with a read pending.
      wr(1, 16'h0077); wr(1, 16'h0088);
      rd(1, 16'h0077);
      rd_en = 1'b1; rd_ch = 2'd1; clear = 1'b1;
      cyc();
      rd_en = 1'b0; clear = 1'b0;
      chk("clear_rd_valid", 32'(rd_valid), 32'h0);
      chk("clear_rd_data", 32'(rd_data), 32'h0);
      chk("clear_empty", 32'(empty), 32'hF);
      chk("clear_rd_ch_q", 32'(rd_ch_q), 32'h0);
      repeat (3) cyc();
      chk("sb_drain", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
